hazard_ctrl: RTL and testbench



---
 rtl/hazard_ctrl_if.sv | 27 ++
 rtl/hazard_ctrl.sv | 73 +++++++
 tb/tb_hazard_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-side hazard inputs and the controller's enable/flush/stall outputs
interface hazard_ctrl_if #(parameter int REG_W = 5);
   logic             ex_mem_read;
   logic [REG_W-1:0] ex_rd;
   logic [REG_W-1:0] id_rs;
   logic [REG_W-1:0] id_rt;
   logic             id_use_rt;
   logic             ex_br_taken;
   logic             ex_jump;
   logic             mem_req;
   logic             mem_ready;
   logic             pc_write;
   logic             ifid_write;
   logic             ifid_flush;
   logic             idex_flush;
   logic             exmem_stall;
   logic [1:0]       state;
   logic             timeout;
   modport master (
      output ex_mem_read, ex_rd, id_rs, id_rt, id_use_rt, ex_br_taken, ex_jump, mem_req, mem_ready,
      input  pc_write, ifid_write, ifid_flush, idex_flush, exmem_stall, state, timeout
   );
   modport slave (
      input  ex_mem_read, ex_rd, id_rs, id_rt, id_use_rt, ex_br_taken, ex_jump, mem_req, mem_ready,
      output pc_write, ifid_write, ifid_flush, idex_flush, exmem_stall, state, timeout
   );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use bubbles, branch/jump squash and data-memory wait/timeout control
module hazard_ctrl #(
   parameter int REG_W        = 5,
   parameter int FLUSH_CYCLES = 2,
   parameter int MEM_TIMEOUT  = 15
) (
   input logic         clk,
   input logic         rst_n,
   hazard_ctrl_if.slave hz
);
   localparam int WW = ($clog2(MEM_TIMEOUT + 1) > 4) ? $clog2(MEM_TIMEOUT + 1) : 4;
   typedef enum logic [1:0] {IDLE = 2'd0, FLUSH = 2'd1, MEM_WAIT = 2'd2, ERR = 2'd3} state_t;
   state_t        st;
   logic [2:0]    fcnt;
   logic [WW-1:0] wcnt;
   logic [WW-1:0] wcnt_inc;
   logic          to;
   logic          lu, mw, rd, idle_like, frz, fl, bub;
   assign lu = hz.ex_mem_read && hz.ex_rd != REG_W'(0) &&
               (hz.ex_rd == hz.id_rs || (hz.id_use_rt && hz.ex_rd == hz.id_rt));
   assign mw = hz.mem_req && !hz.mem_ready;
   assign rd = hz.ex_br_taken || hz.ex_jump;
   // a released memory wait behaves as IDLE for that cycle, so a held redirect is serviced
   assign idle_like = st == IDLE || (st == MEM_WAIT && hz.mem_ready);
   assign frz = st == ERR || (st == MEM_WAIT && !hz.mem_ready) || mw;
   assign fl = st == FLUSH || (idle_like && !mw && rd);
   assign bub = idle_like && !mw && !rd && lu;
   assign wcnt_inc = wcnt + 1'b1;
   always_comb begin
      hz.pc_write = rst_n && !frz && !bub;
      hz.ifid_write = rst_n && !frz && !bub;
      hz.ifid_flush = !rst_n || fl;
      hz.idex_flush = !rst_n || fl || bub;
      hz.exmem_stall = rst_n && frz;
   end
   assign hz.state = st;
   assign hz.timeout = to;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st <= IDLE;
         fcnt <= 3'd0;
         wcnt <= '0;
         to <= 1'b0;
      end else begin
         case (st)
            IDLE, MEM_WAIT: begin
               if (st == MEM_WAIT && !hz.mem_ready) begin
                  wcnt <= wcnt_inc;
                  if (wcnt_inc >= WW'(MEM_TIMEOUT)) begin
                     st <= ERR;
                     to <= 1'b1;
                  end
               end else if (mw) begin
                  st <= MEM_WAIT;
                  wcnt <= WW'(1);
               end else if (rd && FLUSH_CYCLES > 1) begin
                  st <= FLUSH;
                  fcnt <= 3'(FLUSH_CYCLES - 1);
               end else begin
                  st <= IDLE;
               end
            end
            FLUSH: begin
               if (!mw) begin
                  fcnt <= fcnt - 3'd1;
                  if (fcnt == 3'd1) st <= IDLE;
               end
            end
            default: st <= ERR;
         endcase
      end
   end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors checked against a cycle model and hand-computed literals
module tb_hazard_ctrl;
   localparam int FC = 2;
   localparam int TO = 15;
   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   hazard_ctrl_if #(.REG_W(5)) hz ();
   hazard_ctrl #(.REG_W(5), .FLUSH_CYCLES(FC), .MEM_TIMEOUT(TO)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .hz(hz)
   );
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end
   // model: remaining flush cycles, whether a memory wait is pending, cycles waited, fault flag
   int flush_left = 0;
   int waited = 0;
   bit waiting = 0;
   bit fault = 0;
   always @(negedge clk) begin
      logic [7:0] got, exp_v;
      logic e_pc, e_ifw, e_iff, e_idf, e_st, e_to, mw, rd, lu;
      logic [1:0] e_state;
      got = {hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_flush, hz.exmem_stall, hz.state, hz.timeout};
      if (!rst_n) begin
         flush_left = 0;
         waited = 0;
         waiting = 0;
         fault = 0;
         exp_v = 8'b0011_0000;
      end else begin
         mw = hz.mem_req && !hz.mem_ready;
         rd = hz.ex_br_taken || hz.ex_jump;
         lu = hz.ex_mem_read && hz.ex_rd != 0 &&
              (hz.ex_rd == hz.id_rs || (hz.id_use_rt && hz.ex_rd == hz.id_rt));
         e_state = fault ? 2'd3 : waiting ? 2'd2 : flush_left > 0 ? 2'd1 : 2'd0;
         e_to = fault;
         {e_pc, e_ifw, e_iff, e_idf, e_st} = 5'b11000;
         if (fault) begin
            {e_pc, e_ifw, e_st} = 3'b001;
         end else if (waiting && !hz.mem_ready) begin
            {e_pc, e_ifw, e_st} = 3'b001;
            waited++;
            if (waited >= TO) fault = 1;
         end else if (flush_left > 0) begin
            {e_iff, e_idf} = 2'b11;
            if (mw) {e_pc, e_ifw, e_st} = 3'b001;
            else flush_left--;
         end else begin
            waiting = 0;
            if (mw) begin
               {e_pc, e_ifw, e_st} = 3'b001;
               waiting = 1;
               waited = 1;
            end else if (rd) begin
               {e_iff, e_idf} = 2'b11;
               flush_left = FC - 1;
            end else if (lu) begin
               {e_pc, e_ifw, e_idf} = 3'b001;
            end
         end
         exp_v = {e_pc, e_ifw, e_iff, e_idf, e_st, e_state, e_to};
      end
      checks++;
      if (got !== exp_v) begin
         errors++;
         $display("FAIL cycle_outputs t=%0t got %b expected %b", $time, got, exp_v);
      end
   end
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp_v);
      checks++;
      if (got !== exp_v) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, got, exp_v);
      end
   endtask
   task automatic drv(input logic mr, input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urt, input logic br, input logic j, input logic req, input logic rdy);
      hz.ex_mem_read = mr;
      hz.ex_rd = rd;
      hz.id_rs = rs;
      hz.id_rt = rt;
      hz.id_use_rt = urt;
      hz.ex_br_taken = br;
      hz.ex_jump = j;
      hz.mem_req = req;
      hz.mem_ready = rdy;
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   initial begin
      rst_n = 1'b1;
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_pc", hz.pc_write, 0);
      chk("rst_ifw", hz.ifid_write, 0);
      chk("rst_iff", hz.ifid_flush, 1);
      chk("rst_idf", hz.idex_flush, 1);
      chk("rst_stall", hz.exmem_stall, 0);
      chk("rst_state", hz.state, 0);
      chk("rst_timeout", hz.timeout, 0);
      tick;
      tick;
      rst_n = 1'b1;
      tick;
      #2;
      chk("idle_pc", hz.pc_write, 1);
      chk("idle_ifw", hz.ifid_write, 1);
      chk("idle_iff", hz.ifid_flush, 0);
      chk("idle_stall", hz.exmem_stall, 0);
      chk("idle_state", hz.state, 0);
      tick;
      drv(1, 8, 8, 0, 0, 0, 0, 0, 1);
      #2;
      chk("lu_pc", hz.pc_write, 0);
      chk("lu_ifw", hz.ifid_write, 0);
      chk("lu_idf", hz.idex_flush, 1);
      chk("lu_iff", hz.ifid_flush, 0);
      tick;
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
      #2 chk("lu_clear_pc", hz.pc_write, 1);
      tick;
      drv(1, 0, 0, 0, 0, 0, 0, 0, 1);
      #2 chk("lu_rd0_pc", hz.pc_write, 1);
      tick;
      drv(1, 8, 3, 8, 0, 0, 0, 0, 1);
      #2 chk("lu_nouse_rt_pc", hz.pc_write, 1);
      tick;
      drv(1, 8, 3, 8, 1, 0, 0, 0, 1);
      #2 chk("lu_rt_pc", hz.pc_write, 0);
      tick;
      drv(1, 8, 8, 0, 0, 1, 0, 0, 1);
      #2;
      chk("br_iff", hz.ifid_flush, 1);
      chk("br_idf", hz.idex_flush, 1);
      chk("br_over_lu_pc", hz.pc_write, 1);
      chk("br_state", hz.state, 0);
      tick;
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
      #2;
      chk("flush_state", hz.state, 1);
      chk("flush_iff", hz.ifid_flush, 1);
      chk("flush_idf", hz.idex_flush, 1);
      tick;
      #2;
      chk("flush_done_state", hz.state, 0);
      chk("flush_done_iff", hz.ifid_flush, 0);
      tick;
      for (int i = 0; i < 4; i++) begin
         drv(0, 0, 0, 0, 0, 0, 1, 1, 0);
         #2;
         chk("mw_stall", hz.exmem_stall, 1);
         chk("mw_pc", hz.pc_write, 0);
         chk("mw_iff", hz.ifid_flush, 0);
         chk("mw_state", hz.state, (i == 0) ? 0 : 2);
         tick;
      end
      drv(0, 0, 0, 0, 0, 0, 1, 1, 1);
      #2;
      chk("rel_iff", hz.ifid_flush, 1);
      chk("rel_pc", hz.pc_write, 1);
      chk("rel_stall", hz.exmem_stall, 0);
      chk("rel_state", hz.state, 2);
      tick;
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
      #2 chk("rel_flush_state", hz.state, 1);
      tick;
      #2 chk("rel_idle_state", hz.state, 0);
      tick;
      drv(0, 0, 0, 0, 0, 1, 0, 0, 1);
      tick;
      drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
      #2;
      chk("fmw_state", hz.state, 1);
      chk("fmw_stall", hz.exmem_stall, 1);
      chk("fmw_iff", hz.ifid_flush, 1);
      chk("fmw_pc", hz.pc_write, 0);
      tick;
      drv(0, 0, 0, 0, 0, 0, 0, 1, 1);
      #2;
      chk("fmw_rel_state", hz.state, 1);
      chk("fmw_rel_stall", hz.exmem_stall, 0);
      tick;
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
      #2 chk("fmw_idle_state", hz.state, 0);
      tick;
      for (int i = 1; i <= TO; i++) begin
         drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
         #2;
         if (i == TO) begin
            chk("to_last_wait_state", hz.state, 2);
            chk("to_last_wait_flag", hz.timeout, 0);
         end
         tick;
      end
      drv(0, 0, 0, 0, 0, 0, 0, 1, 1);
      #2;
      chk("to_state", hz.state, 3);
      chk("to_flag", hz.timeout, 1);
      chk("to_pc", hz.pc_write, 0);
      chk("to_stall", hz.exmem_stall, 1);
      tick;
      drv(0, 0, 0, 0, 0, 1, 0, 0, 1);
      #2;
      chk("to_sticky_flag", hz.timeout, 1);
      chk("to_sticky_state", hz.state, 3);
      chk("err_no_flush", hz.ifid_flush, 0);
      tick;
      rst_n = 1'b0;
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick;
      rst_n = 1'b1;
      #2 chk("to_cleared", hz.timeout, 0);
      tick;
      drv(0, 0, 0, 0, 0, 1, 0, 0, 1);
      tick;
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
      #2 chk("mid_flush_state", hz.state, 1);
      rst_n = 1'b0;
      #1;
      chk("ar_state", hz.state, 0);
      chk("ar_pc", hz.pc_write, 0);
      chk("ar_ifw", hz.ifid_write, 0);
      chk("ar_iff", hz.ifid_flush, 1);
      chk("ar_idf", hz.idex_flush, 1);
      chk("ar_stall", hz.exmem_stall, 0);
      tick;
      rst_n = 1'b1;
      tick;
      #2 chk("post_ar_state", hz.state, 0);
      tick;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
